// File: rtl/perc_var_pkg.sv
// Shared constants, FSM state type and LAR helper for the perc_var perceptual-weighting block.
package perc_var_pkg;

  localparam int MEM_DEPTH = 2048;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 11;

  localparam logic [ADDR_W-1:0] LEVINSON_DURBIN_RC    = 11'd64;
  localparam logic [ADDR_W-1:0] INTERPOLATION_LSF_INT = 11'd96;
  localparam logic [ADDR_W-1:0] INTERPOLATION_LSF_NEW = 11'd128;
  localparam logic [ADDR_W-1:0] PERC_VAR_GAMMA1       = 11'd160;
  localparam logic [ADDR_W-1:0] PERC_VAR_GAMMA2       = 11'd162;

  localparam logic signed [17:0] LAR_BP0  = 18'sd1299;
  localparam logic signed [17:0] LAR_BP1  = 18'sd1815;
  localparam logic signed [17:0] LAR_OFS2 = 18'sd4929;
  localparam logic signed [17:0] LAR_MAX  = 18'sd32767;

  localparam logic signed [15:0] FLAT_CLR_L0 = -16'sd3564;
  localparam logic signed [15:0] FLAT_CLR_L1 = 16'sd1331;
  localparam logic signed [15:0] FLAT_SET_L0 = -16'sd3113;
  localparam logic signed [15:0] FLAT_SET_L1 = 16'sd881;

  localparam logic [15:0]        GAMMA1_FLAT  = 16'd30802;
  localparam logic [15:0]        GAMMA1_STEEP = 16'd32113;
  localparam logic [15:0]        GAMMA2_STEEP = 16'd13107;
  localparam logic signed [31:0] GAMMA2_MIN   = 32'sd13107;
  localparam logic signed [31:0] GAMMA2_MAX   = 32'sd22938;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    READ_RC     = 4'd1,
    LAR         = 4'd2,
    SUB0_DMIN   = 4'd3,
    SUB0_DECIDE = 4'd4,
    SUB0_WRITE  = 4'd5,
    SUB1_DMIN   = 4'd6,
    SUB1_DECIDE = 4'd7,
    SUB1_WRITE  = 4'd8,
    DONE        = 4'd9
  } perc_state_e;

  // Piecewise-linear log-area-ratio of one reflection coefficient, Q11.
  function automatic logic signed [15:0] lar_f(input logic signed [15:0] rc);
    logic signed [17:0] mag;
    logic signed [17:0] x;
    logic signed [17:0] l;
    mag = (rc < 16'sd0) ? -{{2{rc[15]}}, rc} : {{2{rc[15]}}, rc};
    x   = mag >>> 4;
    if (x < LAR_BP0)      l = x;
    else if (x < LAR_BP1) l = (x <<< 1) - LAR_BP0;
    else                  l = (x <<< 2) - LAR_OFS2;
    if (l > LAR_MAX) l = LAR_MAX;
    if (rc > 16'sd0) l = -l;
    return l[15:0];
  endfunction

endpackage

// File: rtl/perc_var_scratch_mem.sv
// 2048x32 single-clock scratch RAM; test port owns both ports when mux_sel_i is high.
module perc_var_scratch_mem
  import perc_var_pkg::*;
(
  input  logic              clk_i,
  input  logic              mux_sel_i,
  input  logic              test_we_i,
  input  logic [DATA_W-1:0] test_wdata_i,
  input  logic [ADDR_W-1:0] test_waddr_i,
  input  logic [ADDR_W-1:0] test_raddr_i,
  input  logic              fsm_we_i,
  input  logic [DATA_W-1:0] fsm_wdata_i,
  input  logic [ADDR_W-1:0] fsm_waddr_i,
  input  logic [ADDR_W-1:0] fsm_raddr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [0:MEM_DEPTH-1];
  logic [DATA_W-1:0] rd_data_q;
  logic              we_s;
  logic [DATA_W-1:0] wdata_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [ADDR_W-1:0] raddr_s;

  assign we_s    = mux_sel_i ? test_we_i    : fsm_we_i;
  assign wdata_s = mux_sel_i ? test_wdata_i : fsm_wdata_i;
  assign waddr_s = mux_sel_i ? test_waddr_i : fsm_waddr_i;
  assign raddr_s = mux_sel_i ? test_raddr_i : fsm_raddr_i;

  // Write port and registered read port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_s) mem_q[waddr_s] <= wdata_s;
    rd_data_q <= mem_q[raddr_s];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/perc_var_top.sv
// G.729 perceptual-weighting adaptation: LAR-based flat/steep decision and gamma1/gamma2 per subframe.
// Optional debug outputs flatFlag/dminOut are enabled by defining PERC_VAR_DEBUG_EN.
module perc_var_top
  import perc_var_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              percVarMuxSel,
  input  logic              testMemWrite,
  input  logic [DATA_W-1:0] testMemOut,
  input  logic [ADDR_W-1:0] testWriteAddr,
  input  logic [ADDR_W-1:0] testReadAddr,
  output logic [DATA_W-1:0] memIn,
`ifdef PERC_VAR_DEBUG_EN
  output logic              flatFlag,
  output logic [15:0]       dminOut,
`endif
  output logic              done
);

  perc_state_e        state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic signed [15:0] rc0_q, rc1_q, prev_q;
  logic signed [15:0] lar_new0_q, lar_new1_q, lar_old0_q, lar_old1_q;
  logic signed [16:0] dmin_q, diff_s, sum0_s, sum1_s;
  logic signed [15:0] sub_lar0_s, sub_lar1_s;
  logic signed [31:0] g2_raw_s;
  logic               flat_q, flat_d, done_q;
  logic [15:0]        gamma1_q, gamma2_q, gamma1_d, gamma2_d;
  logic [ADDR_W-1:0]  rd_addr_s, wr_addr_s;
  logic [DATA_W-1:0]  wr_data_s;
  logic               wr_en_s;

  perc_var_scratch_mem u_mem (
    .clk_i       (clk),
    .mux_sel_i   (percVarMuxSel),
    .test_we_i   (testMemWrite),
    .test_wdata_i(testMemOut),
    .test_waddr_i(testWriteAddr),
    .test_raddr_i(testReadAddr),
    .fsm_we_i    (wr_en_s),
    .fsm_wdata_i (wr_data_s),
    .fsm_waddr_i (wr_addr_s),
    .fsm_raddr_i (rd_addr_s),
    .rd_data_o   (memIn)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; phase counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (start) state_d = READ_RC; else state_d = IDLE;
      READ_RC:     if (cnt_q == 4'd2) state_d = LAR; else state_d = READ_RC;
      LAR:         state_d = SUB0_DMIN;
      SUB0_DMIN:   if (cnt_q == 4'd10) state_d = SUB0_DECIDE; else state_d = SUB0_DMIN;
      SUB0_DECIDE: state_d = SUB0_WRITE;
      SUB0_WRITE:  if (cnt_q == 4'd1) state_d = SUB1_DMIN; else state_d = SUB0_WRITE;
      SUB1_DMIN:   if (cnt_q == 4'd10) state_d = SUB1_DECIDE; else state_d = SUB1_DMIN;
      SUB1_DECIDE: state_d = SUB1_WRITE;
      SUB1_WRITE:  if (cnt_q == 4'd1) state_d = DONE; else state_d = SUB1_WRITE;
      DONE:        if (start) state_d = READ_RC; else state_d = DONE;
      default:     state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
  end

  // Memory addressing: read rc/lsf words by phase, write gamma1 then gamma2.
  always_comb begin
    rd_addr_s = {ADDR_W{1'b0}};
    wr_addr_s = {ADDR_W{1'b0}};
    wr_data_s = {DATA_W{1'b0}};
    wr_en_s   = 1'b0;
    case (state_q)
      READ_RC:   rd_addr_s = LEVINSON_DURBIN_RC + {10'd0, cnt_q[0]};
      SUB0_DMIN: rd_addr_s = INTERPOLATION_LSF_INT + {7'd0, cnt_q};
      SUB1_DMIN: rd_addr_s = INTERPOLATION_LSF_NEW + {7'd0, cnt_q};
      SUB0_WRITE: begin
        wr_en_s   = 1'b1;
        wr_addr_s = cnt_q[0] ? PERC_VAR_GAMMA2 : PERC_VAR_GAMMA1;
        wr_data_s = {16'd0, (cnt_q[0] ? gamma2_q : gamma1_q)};
      end
      SUB1_WRITE: begin
        wr_en_s   = 1'b1;
        wr_addr_s = (cnt_q[0] ? PERC_VAR_GAMMA2 : PERC_VAR_GAMMA1) + 11'd1;
        wr_data_s = {16'd0, (cnt_q[0] ? gamma2_q : gamma1_q)};
      end
      default: wr_en_s = 1'b0;
    endcase
  end

  // Subframe LARs, flat hysteresis and gamma selection/clipping.
  always_comb begin
    sum0_s = {lar_old0_q[15], lar_old0_q} + {lar_new0_q[15], lar_new0_q};
    sum1_s = {lar_old1_q[15], lar_old1_q} + {lar_new1_q[15], lar_new1_q};
    if (state_q == SUB0_DECIDE) begin
      sub_lar0_s = sum0_s[16:1];
      sub_lar1_s = sum1_s[16:1];
    end else begin
      sub_lar0_s = lar_new0_q;
      sub_lar1_s = lar_new1_q;
    end
    if (flat_q && (sub_lar0_s < FLAT_CLR_L0) && (sub_lar1_s > FLAT_CLR_L1))       flat_d = 1'b0;
    else if (!flat_q && ((sub_lar0_s > FLAT_SET_L0) || (sub_lar1_s < FLAT_SET_L1))) flat_d = 1'b1;
    else                                                                           flat_d = flat_q;
    g2_raw_s = 32'sd32768 - 32'sd24 * {{15{dmin_q[16]}}, dmin_q};
    if (flat_d) begin
      gamma1_d = GAMMA1_FLAT;
      if (g2_raw_s > GAMMA2_MAX)      gamma2_d = GAMMA2_MAX[15:0];
      else if (g2_raw_s < GAMMA2_MIN) gamma2_d = GAMMA2_MIN[15:0];
      else                            gamma2_d = g2_raw_s[15:0];
    end else begin
      gamma1_d = GAMMA1_STEEP;
      gamma2_d = GAMMA2_STEEP;
    end
    diff_s = $signed({memIn[15], memIn[15:0]}) - $signed({prev_q[15], prev_q});
  end

  // Datapath registers: rc capture, LAR, running dmin, flat state, gammas, done.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0; rc0_q <= 16'sd0; rc1_q <= 16'sd0; prev_q <= 16'sd0;
      lar_new0_q <= 16'sd0; lar_new1_q <= 16'sd0; lar_old0_q <= 16'sd0; lar_old1_q <= 16'sd0;
      dmin_q <= 17'sd0; flat_q <= 1'b1; gamma1_q <= 16'd0; gamma2_q <= 16'd0; done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (state_d == DONE);
      case (state_q)
        READ_RC: begin
          if (cnt_q == 4'd1) rc0_q <= memIn[15:0];
          if (cnt_q == 4'd2) rc1_q <= memIn[15:0];
        end
        LAR: begin
          lar_new0_q <= lar_f(rc0_q);
          lar_new1_q <= lar_f(rc1_q);
        end
        SUB0_DMIN, SUB1_DMIN: begin
          if (cnt_q != 4'd0) prev_q <= memIn[15:0];
          if (cnt_q == 4'd2) dmin_q <= diff_s;
          else if ((cnt_q > 4'd2) && (diff_s < dmin_q)) dmin_q <= diff_s;
        end
        SUB0_DECIDE, SUB1_DECIDE: begin
          flat_q   <= flat_d;
          gamma1_q <= gamma1_d;
          gamma2_q <= gamma2_d;
        end
        SUB1_WRITE: begin
          if (cnt_q == 4'd1) begin
            lar_old0_q <= lar_new0_q;
            lar_old1_q <= lar_new1_q;
          end
        end
        default: cnt_q <= cnt_d;
      endcase
    end
  end

  assign done = done_q;

`ifdef PERC_VAR_DEBUG_EN
  logic [15:0] dmin_last_q;

  // Last dmin used for a gamma decision.
  always_ff @(posedge clk) begin
    if (reset) dmin_last_q <= 16'd0;
    else if ((state_q == SUB0_DECIDE) || (state_q == SUB1_DECIDE)) dmin_last_q <= dmin_q[15:0];
    else dmin_last_q <= dmin_last_q;
  end

  assign flatFlag = flat_q;
  assign dminOut  = dmin_last_q;
`endif

endmodule

// File: tb/tb_perc_var_top.sv
// Self-checking bench for perc_var_top: directed and randomized frames against a behavioural model.
module tb_perc_var_top;
  import perc_var_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, percVarMuxSel, testMemWrite;
  logic [31:0] testMemOut, memIn;
  logic [10:0] testWriteAddr, testReadAddr;
  logic        done;
`ifdef PERC_VAR_DEBUG_EN
  logic        flatFlag;
  logic [15:0] dminOut;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int rc_v[2];
  int lsf_int[10];
  int lsf_new[10];
  int m_flat;
  int m_lar_old[2];

  always #5 clk = ~clk;

  perc_var_top dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .percVarMuxSel(percVarMuxSel),
    .testMemWrite (testMemWrite),
    .testMemOut   (testMemOut),
    .testWriteAddr(testWriteAddr),
    .testReadAddr (testReadAddr),
    .memIn        (memIn),
`ifdef PERC_VAR_DEBUG_EN
    .flatFlag     (flatFlag),
    .dminOut      (dminOut),
`endif
    .done         (done)
  );

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lar_m(input int rc);
    int x, l;
    x = ((rc < 0) ? -rc : rc) / 16;
    if (x < 1299)      l = x;
    else if (x < 1815) l = 2 * x - 1299;
    else               l = 4 * x - 4929;
    if (l > 32767) l = 32767;
    return (rc > 0) ? -l : l;
  endfunction

  function automatic int dmin_m(input int sub);
    int d, best;
    best = 1 << 30;
    for (int i = 0; i < 9; i++) begin
      d = (sub == 0) ? lsf_int[i+1] - lsf_int[i] : lsf_new[i+1] - lsf_new[i];
      if (d < best) best = d;
    end
    return best;
  endfunction

  task automatic write_word(input logic [10:0] a, input logic [31:0] d);
    @(negedge clk);
    percVarMuxSel = 1'b1; testMemWrite = 1'b1; testWriteAddr = a; testMemOut = d;
    @(negedge clk);
    testMemWrite = 1'b0;
  endtask

  task automatic read_word(input logic [10:0] a, output logic [31:0] d);
    @(negedge clk);
    percVarMuxSel = 1'b1; testReadAddr = a;
    @(negedge clk);
    d = memIn;
  endtask

  task automatic set_uniform(input int base, input int sp);
    for (int i = 0; i < 10; i++) begin
      lsf_int[i] = base + i * sp;
      lsf_new[i] = base + i * sp;
    end
  endtask

  task automatic load_inputs();
    for (int i = 0; i < 2; i++) write_word(LEVINSON_DURBIN_RC + 11'(i), {16'd0, 16'(rc_v[i])});
    for (int i = 0; i < 10; i++) begin
      write_word(INTERPOLATION_LSF_INT + 11'(i), {16'd0, 16'(lsf_int[i])});
      write_word(INTERPOLATION_LSF_NEW + 11'(i), {16'd0, 16'(lsf_new[i])});
    end
    for (int k = 0; k < 2; k++) begin
      write_word(PERC_VAR_GAMMA1 + 11'(k), 32'hDEAD_BEEF);
      write_word(PERC_VAR_GAMMA2 + 11'(k), 32'hDEAD_BEEF);
    end
  endtask

  task automatic run_frame(input string tag);
    int lnew[2];
    int l0, l1, g1, g2, cyc;
    int exp_g1[2];
    int exp_g2[2];
    logic [31:0] rd;
    load_inputs();
    @(negedge clk);
    percVarMuxSel = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val({tag, "_done_clr"}, done, 0);
    cyc = 1;
    while (done !== 1'b1 && cyc < 120) begin
      @(negedge clk);
      cyc++;
    end
    check_val({tag, "_done_lat"}, done, 1);
    lnew[0] = lar_m(rc_v[0]);
    lnew[1] = lar_m(rc_v[1]);
    for (int k = 0; k < 2; k++) begin
      l0 = (k == 0) ? (m_lar_old[0] + lnew[0]) >>> 1 : lnew[0];
      l1 = (k == 0) ? (m_lar_old[1] + lnew[1]) >>> 1 : lnew[1];
      if (m_flat == 1 && l0 < -3564 && l1 > 1331)        m_flat = 0;
      else if (m_flat == 0 && (l0 > -3113 || l1 < 881))  m_flat = 1;
      if (m_flat == 1) begin
        g1 = 30802;
        g2 = 32768 - 24 * dmin_m(k);
        if (g2 > 22938) g2 = 22938;
        if (g2 < 13107) g2 = 13107;
      end else begin
        g1 = 32113;
        g2 = 13107;
      end
      exp_g1[k] = g1;
      exp_g2[k] = g2;
    end
    m_lar_old = lnew;
    for (int k = 0; k < 2; k++) begin
      read_word(PERC_VAR_GAMMA1 + 11'(k), rd);
      check_val($sformatf("%s_g1_%0d", tag, k), rd, exp_g1[k]);
      read_word(PERC_VAR_GAMMA2 + 11'(k), rd);
      check_val($sformatf("%s_g2_%0d", tag, k), rd, exp_g2[k]);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] tp_data[8];
    reset = 1'b1; start = 1'b0; percVarMuxSel = 1'b1; testMemWrite = 1'b0;
    testMemOut = 32'd0; testWriteAddr = 11'd0; testReadAddr = 11'd0;
    m_flat = 1; m_lar_old[0] = 0; m_lar_old[1] = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_val("reset_done", done, 0);

    rc_v[0] = 32'h0100; rc_v[1] = 32'h0200;
    set_uniform(32'h0400, 32'h0A00); run_frame("sp0a00");
    set_uniform(32'h0400, 32'h0100); run_frame("sp0100");
    set_uniform(32'h0400, 32'h0180); run_frame("sp0180");
    set_uniform(32'h0400, 32'h0200); run_frame("sp0200");

    rc_v[0] = 32'h7F00; rc_v[1] = 32'h8100 - 32'h10000;
    set_uniform(32'h0400, 32'h0200);
    run_frame("steep1");
    run_frame("steep2");

    for (int t = 0; t < 6; t++) begin
      rc_v[0] = int'($urandom_range(0, 65535)) - 32768;
      rc_v[1] = int'($urandom_range(0, 65535)) - 32768;
      lsf_int[0] = int'($urandom_range(0, 3000));
      lsf_new[0] = int'($urandom_range(0, 3000));
      for (int i = 1; i < 10; i++) begin
        lsf_int[i] = lsf_int[i-1] + int'($urandom_range(0, 3000)) - 200;
        lsf_new[i] = lsf_new[i-1] + int'($urandom_range(0, 3000)) - 200;
      end
      run_frame($sformatf("rnd%0d", t));
    end

    // Reset in the middle of a frame, then rerun the first scenario.
    rc_v[0] = 32'h0100; rc_v[1] = 32'h0200;
    set_uniform(32'h0400, 32'h0A00);
    load_inputs();
    @(negedge clk);
    percVarMuxSel = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_val("midrst_done", done, 0);
    m_flat = 1; m_lar_old[0] = 0; m_lar_old[1] = 0;
    read_word(LEVINSON_DURBIN_RC, rd);
    check_val("midrst_mem_kept", rd, 32'h0100);
    run_frame("after_rst");

    for (int i = 0; i < 8; i++) begin
      tp_data[i] = $urandom;
      write_word(11'(1024 + i * 37), tp_data[i]);
    end
    for (int i = 0; i < 8; i++) begin
      read_word(11'(1024 + i * 37), rd);
      check_val($sformatf("tport_%0d", i), rd, tp_data[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
